// File: rtl/uart_tx.sv
// UART transmitter: small input FIFO feeding an LSB-first serialiser
// (start, data, optional parity, stop bits), paced by an external baud_tick strobe.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            baud_tick,
    input  logic [DATA_WIDTH-1:0]           tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            tx_serial,
    output logic                            tx_busy,
    output logic                            tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic [2:0]                      o_dbg_state
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_parity, w_parity_nxt;
    logic [BW-1:0]         r_bit_idx, w_bit_idx_nxt;
    logic                  r_stop_cnt, w_stop_cnt_nxt;
    logic                  r_serial, w_serial_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_push, w_pop, w_full, w_empty;

    // Handshake: a word transfers on any rising edge where tx_valid && tx_ready;
    // tx_ready depends only on the registered count, so a same-cycle pop never frees a slot.
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = tx_valid && !w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= tx_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_serial   <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_serial   <= w_serial_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        w_serial_nxt   = r_serial;
        w_done_nxt     = 1'b0;
        w_pop          = 1'b0;
        if (baud_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_serial_nxt = 1'b0;
                        w_state_nxt  = S_START;
                    end
                end
                S_START: begin
                    w_serial_nxt  = r_shift[0];
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
                S_DATA: begin
                    if (r_bit_idx == BW'(DATA_WIDTH - 1)) begin
                        w_stop_cnt_nxt = 1'b0;
                        if (PARITY_EN != 0) begin
                            w_serial_nxt = r_parity;
                            w_state_nxt  = S_PARITY;
                        end else begin
                            w_serial_nxt = 1'b1;
                            w_state_nxt  = S_STOP;
                        end
                    end else begin
                        // Shift so the bit on the line is always r_shift[0]
                        w_bit_idx_nxt = r_bit_idx + BW'(1);
                        w_shift_nxt   = r_shift >> 1;
                        w_serial_nxt  = r_shift[1];
                    end
                end
                S_PARITY: begin
                    w_serial_nxt   = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = S_STOP;
                end
                S_STOP: begin
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_done_nxt = 1'b1;
                        if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_serial_nxt = 1'b0;
                            w_state_nxt  = S_START;
                        end else begin
                            w_serial_nxt = 1'b1;
                            w_state_nxt  = S_IDLE;
                        end
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
                default: begin
                    w_serial_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            endcase
        end
        // Capture the word and its parity at pop so later FIFO writes cannot disturb the frame
        if (w_pop) begin
            w_shift_nxt  = r_mem[r_rd_ptr];
            w_parity_nxt = (^r_mem[r_rd_ptr]) ^ (PARITY_ODD != 0);
        end
    end

    always_comb begin
        tx_serial   = r_serial;
        tx_done     = r_done;
        tx_busy     = (r_state != S_IDLE);
        tx_ready    = !w_full;
        fifo_count  = r_count;
        o_dbg_state = r_state;
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E2, 8O2) share one stimulus stream;
// a line monitor per instance rebuilds frames and checks them against queued expectations.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [2:0] ready, ser, busy, done;
    logic [2:0] cnt [3];
    logic [2:0] dbg [3];

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];
    logic [11:0] exp_q2[$];

    bit          tick_q, reset_q;
    bit          mon_act [3];
    int          mon_cnt [3];
    logic [11:0] mon_bits [3];

    always #5 clk = ~clk;

    uart_tx dut0 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready[0]), .tx_serial(ser[0]), .tx_busy(busy[0]),
        .tx_done(done[0]), .fifo_count(cnt[0]), .o_dbg_state(dbg[0])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready[1]), .tx_serial(ser[1]), .tx_busy(busy[1]),
        .tx_done(done[1]), .fifo_count(cnt[1]), .o_dbg_state(dbg[1])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready[2]), .tx_serial(ser[2]), .tx_busy(busy[2]),
        .tx_done(done[2]), .fifo_count(cnt[2]), .o_dbg_state(dbg[2])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h, want %0h", name, k, act, exp);
        end
    endtask

    function automatic int flen(input int k);
        return (k == 0) ? 10 : 12;
    endfunction

    // Frame as seen on the line, bit 0 first: start, data LSB-first, parity, stops.
    function automatic logic [11:0] frame_of(input logic [7:0] d, input bit pen, input bit podd, input int nstop);
        logic [11:0] f;
        int          idx;
        f      = '0;
        f[8:1] = d;
        idx    = 9;
        if (pen) begin
            f[9] = (^d) ^ podd;
            idx  = 10;
        end
        for (int s = 0; s < nstop; s++) f[idx + s] = 1'b1;
        return f;
    endfunction

    function automatic int exp_size(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [11:0] exp_pop(input int k);
        case (k)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    function automatic void exp_clear(input int k);
        case (k)
            0:       exp_q0.delete();
            1:       exp_q1.delete();
            default: exp_q2.delete();
        endcase
    endfunction

    always @(posedge clk) begin
        tick_q  <= baud_tick;
        reset_q <= reset;
    end

    // Line monitor: samples each line value right after the tick that launched it.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset_q) begin
                mon_act[k] = 1'b0;
                mon_cnt[k] = 0;
                exp_clear(k);
            end else begin
                if (done[k] === 1'b1 && !(tick_q && mon_act[k] && mon_cnt[k] == flen(k))) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_done dut%0d: got tx_done 1, want 0", k);
                end
                if (tick_q) begin
                    if (mon_act[k] && mon_cnt[k] == flen(k)) begin
                        bit more;
                        chk("done_pulse", k, done[k], 1);
                        if (exp_size(k) == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL frame_unexpected dut%0d: got frame %0h, want none", k, mon_bits[k]);
                        end else begin
                            chk("frame", k, mon_bits[k], exp_pop(k));
                        end
                        more = (exp_size(k) != 0);
                        chk("next_line", k, ser[k], !more);
                        chk("busy_after", k, busy[k], more);
                        mon_act[k]  = (ser[k] == 1'b0);
                        mon_cnt[k]  = 1;
                        mon_bits[k] = '0;
                    end else if (mon_act[k]) begin
                        mon_bits[k][mon_cnt[k]] = ser[k];
                        mon_cnt[k]++;
                        chk("busy_frame", k, busy[k], 1);
                    end else if (ser[k] == 1'b0) begin
                        mon_act[k]  = 1'b1;
                        mon_cnt[k]  = 1;
                        mon_bits[k] = '0;
                        chk("busy_start", k, busy[k], 1);
                    end
                end
            end
        end
    end

    task automatic cyc(input bit tick, input bit valid, input logic [7:0] d);
        @(negedge clk);
        baud_tick = tick;
        tx_valid  = valid;
        tx_data   = d;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            repeat (gap - 1) cyc(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input logic [11:0] f0, input logic [11:0] f1, input logic [11:0] f2);
        cyc(1'b0, 1'b1, d);
        for (int k = 0; k < 3; k++) chk("push_ready", k, ready[k], 1);
        exp_q0.push_back(f0);
        exp_q1.push_back(f1);
        exp_q2.push_back(f2);
    endtask

    task automatic push_m(input logic [7:0] d);
        push_word(d, frame_of(d, 1'b0, 1'b0, 1), frame_of(d, 1'b1, 1'b0, 2), frame_of(d, 1'b1, 1'b1, 2));
    endtask

    initial begin
        logic [7:0] fill_words [4];
        fill_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset     = 1'b1;
        baud_tick = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_serial", k, ser[k], 1);
            chk("rst_ready", k, ready[k], 1);
            chk("rst_busy", k, busy[k], 0);
            chk("rst_done", k, done[k], 0);
            chk("rst_count", k, cnt[k], 0);
            chk("rst_state", k, dbg[k], 0);
        end
        reset = 1'b0;

        // Single word, hand-derived frames (8N1 0,1,0,1,0,0,1,0,1,1)
        push_word(8'hA5, 12'h34A, 12'hD4A, 12'hF4A);
        ticks(14, 16);

        // Back-to-back: second word queued while the first is on the line
        push_m(8'h01);
        ticks(1, 16);
        push_m(8'hFF);
        ticks(26, 16);

        // Parity word, ticks on consecutive cycles
        push_word(8'h07, 12'h20E, 12'hE0E, 12'hC0E);
        ticks(14, 1);
        repeat (4) cyc(1'b0, 1'b0, 8'h00);

        // FIFO full: tx_valid held with no ticks
        for (int i = 0; i < 4; i++) push_m(fill_words[i]);
        cyc(1'b0, 1'b1, 8'h55);
        for (int k = 0; k < 3; k++) begin
            chk("full_count", k, cnt[k], 4);
            chk("full_ready", k, ready[k], 0);
        end
        cyc(1'b0, 1'b1, 8'h55);
        for (int k = 0; k < 3; k++) chk("full_hold", k, cnt[k], 4);
        cyc(1'b1, 1'b1, 8'h55);
        for (int k = 0; k < 3; k++) chk("full_tick_cnt", k, cnt[k], 4);
        cyc(1'b0, 1'b1, 8'h55);
        for (int k = 0; k < 3; k++) begin
            chk("full_pop_cnt", k, cnt[k], 3);
            chk("full_pop_ready", k, ready[k], 1);
        end
        exp_q0.push_back(frame_of(8'h55, 1'b0, 1'b0, 1));
        exp_q1.push_back(frame_of(8'h55, 1'b1, 1'b0, 2));
        exp_q2.push_back(frame_of(8'h55, 1'b1, 1'b1, 2));
        cyc(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            chk("full_refill_cnt", k, cnt[k], 4);
            chk("full_refill_ready", k, ready[k], 0);
        end
        ticks(64, 16);

        // Reset during data bit 3 with two words still buffered
        push_m(8'hC3);
        push_m(8'h96);
        push_m(8'hE1);
        ticks(5, 16);
        for (int k = 0; k < 3; k++) chk("pre_rst_count", k, cnt[k], 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_serial", k, ser[k], 1);
            chk("mid_rst_count", k, cnt[k], 0);
            chk("mid_rst_busy", k, busy[k], 0);
            chk("mid_rst_done", k, done[k], 0);
            chk("mid_rst_ready", k, ready[k], 1);
        end
        ticks(14, 16);
        push_m(8'h3C);
        ticks(14, 16);

        // Push on the same cycle as an idle tick: start bit waits for the next tick
        cyc(1'b1, 1'b1, 8'h5A);
        for (int k = 0; k < 3; k++) chk("push_ready", k, ready[k], 1);
        exp_q0.push_back(frame_of(8'h5A, 1'b0, 1'b0, 1));
        exp_q1.push_back(frame_of(8'h5A, 1'b1, 1'b0, 2));
        exp_q2.push_back(frame_of(8'h5A, 1'b1, 1'b1, 2));
        cyc(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            chk("pot_no_start", k, ser[k], 1);
            chk("pot_count", k, cnt[k], 1);
        end
        repeat (14) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) chk("pot_start", k, ser[k], 0);
        repeat (14) cyc(1'b0, 1'b0, 8'h00);
        ticks(13, 16);

        repeat (4) cyc(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            chk("drain_queue", k, exp_size(k), 0);
            chk("drain_idle", k, mon_act[k], 0);
            chk("drain_busy", k, busy[k], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter with a small input FIFO, the transmit-side counterpart of the bridge's UART receiver. Accepts parallel words over a valid/ready handshake from the AXI-Lite register layer. Buffers them and serialises each as an LSB-first frame: start bit, data bits, optional parity, stop bit(s). All bit timing is paced by the shared external `baud_tick` strobe.

## Interface
- `DATA_WIDTH`, 8: bits per frame payload.
- `FIFO_DEPTH`, 4: word capacity of the input FIFO; power of two, ≥2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd (ignored when `PARITY_EN`=0).
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous reset, active-high.
- `baud_tick`  input  1  one-`clk`-cycle strobe, once per bit period.
- `tx_data`  input  DATA_WIDTH  word to transmit.
- `tx_valid`  input  1  `tx_data` is valid.
- `tx_ready`  output  1  FIFO can accept a word.
- `tx_serial`  output  1  serial line, idle high, registered.
- `tx_busy`  output  1  a frame is in progress (FSM not IDLE).
- `tx_done`  output  1  one-cycle pulse at the end of each frame.
- `fifo_count`  output  $clog2(FIFO_DEPTH+1)  words currently buffered.

## Operation
- **Reset values:** `tx_serial`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, `fifo_count`=0; FSM in IDLE; FIFO pointers cleared.
- **Push:** occurs when `tx_valid && tx_ready`.
  - `tx_ready` = !full, combinational from the registered count.
  - A push is never accepted while full, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. All transitions occur only on cycles with `baud_tick`=1.
- **IDLE:** `tx_serial`=1.
  - On `baud_tick` with `fifo_count`≠0: pop the FIFO head into the shift register, drive `tx_serial`=0, go to START.
- **START:** on `baud_tick`, drive data bit 0 and go to DATA with bit index 0.
- **DATA:** on each `baud_tick`, advance the bit index and drive the next bit, LSB first.
  - After bit DATA_WIDTH-1 has been held one period: if `PARITY_EN`, drive the parity bit and go to PARITY; otherwise drive 1 and go to STOP.
- **Parity bit:** XOR of all data bits, inverted when `PARITY_ODD`=1.
- **PARITY:** on `baud_tick`, drive 1 and go to STOP.
- **STOP:** `tx_serial`=1 for `STOP_BITS` tick periods.
  - On the final stop `baud_tick`, pulse `tx_done`.
  - If the FIFO is non-empty, pop immediately, drive 0 and go to START (back-to-back frames, no idle bit).
  - Otherwise go to IDLE.
- **Frame length:** 1+DATA_WIDTH+PARITY_EN+STOP_BITS bit periods (10 for 8N1).
- **Pop qualification:** uses the registered count. A word pushed in the same cycle as an IDLE `baud_tick` with an empty FIFO is not popped until the next `baud_tick`.
- **Data capture:** the shift register copies the word at pop time. Later FIFO activity does not affect the frame in flight.
- **Reset mid-frame:** aborts the frame; `tx_serial` returns to 1 at that edge; all buffered words are discarded; no `tx_done` is generated.

## Timing
- `tx_serial` is a flop. It changes on the `clk` edge at which `baud_tick`=1 is sampled, i.e. visible the cycle after the tick strobe.
- Latency from push into an empty, idle block to the start-bit falling edge: up to one bit period, set by the next `baud_tick` after the push cycle.
- `tx_done` rises on the same edge that `tx_serial` enters its next state after the last stop bit. It stays high exactly one `clk` cycle.
- `tx_busy` is high from the edge entering START until the edge entering IDLE. It stays continuously high across back-to-back frames.
- `fifo_count` and `tx_ready` update one edge after the push/pop.
- `baud_tick` held high on consecutive cycles is legal: each high cycle counts as one bit period.

## Test plan
- **8N1, single word:** push 0xA5, `baud_tick` every 16 clks.
  - `tx_serial` bits per tick: 0,1,0,1,0,0,1,0,1,1.
  - One `tx_done` pulse at the 10th tick; `tx_busy` low afterwards.
- **Back-to-back:** push 0x01 then 0xFF while busy.
  - The second start bit immediately follows the first frame's stop bit, with no idle period.
  - Two `tx_done` pulses, 10 ticks apart.
- **Even parity, 2 stop bits** (`PARITY_EN`=1, `STOP_BITS`=2): push 0x07.
  - Parity bit = 1; frame is 12 ticks long.
  - With `PARITY_ODD`=1 the parity bit = 0.
- **FIFO full:** hold `tx_valid` high with no `baud_tick`.
  - Exactly 4 words accepted; `fifo_count`=4; `tx_ready`=0.
  - The 5th word is not accepted until the first pop, then `fifo_count` remains 4.
- **Reset mid-frame:** assert `reset` during DATA bit 3 with 2 words buffered.
  - Next cycle: `tx_serial`=1, `fifo_count`=0, `tx_busy`=0, no `tx_done`.
  - A subsequent push transmits cleanly.
- **Push on tick edge:** push into an empty, idle block on the same cycle as `baud_tick`.
  - No start bit at that tick; the start bit begins at the following tick.
